// File: rtl/instr_fetch_unit.sv
// Fetch initiator: drives pc to imem, registers the returned word into a valid/ready slice.
// Latency: first if_valid two edges after reset release, then 1/cycle; holds while !if_ready.
module instr_fetch_unit #(
  parameter int              ADDR_W    = 5,
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int              CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  input  logic              if_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  issue_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              load;

  // Address comes straight from the pc register so redirect/ready never reach imem.
  assign imem_addr = pc;
  assign load      = !if_valid || if_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_valid    <= 1'b0;
      halted      <= 1'b0;
      issue_count <= '0;
    end else if (redirect_valid) begin
      // A held instruction is dropped; one accepted this cycle was already consumed.
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      halted   <= 1'b0;
      state    <= RUN;
    end else begin
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (load) begin
            if (imem_data == HALT_WORD) begin
              if_valid <= 1'b0;
              halted   <= 1'b1;
              state    <= HALT;
            end else begin
              if_instr <= imem_data;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc + ADDR_W'(1);
              if (issue_count != {CNT_W{1'b1}})
                issue_count <= issue_count + CNT_W'(1);
            end
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-fetch initiator for the single-cycle processor. It drives the program counter onto the instruction memory address bus and captures the returned 32-bit word, which the memory supplies combinationally in the same cycle. It presents each word to the decode stage through a valid/ready register slice. It also handles PC redirects (branch/jump), downstream stalls and a halt instruction.

Parameters:
ADDR_W, 5, instruction memory address width; PC wraps modulo 2^ADDR_W
DATA_W, 32, instruction word width
HALT_WORD, 32'hFFFF_FFFF, fetched word that stops fetching; it is never issued downstream
CNT_W, 16, width of the issued-instruction counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
imem_addr  output  ADDR_W  address to instruction memory; combinationally equal to pc
imem_data  input  DATA_W  instruction word from memory, valid in the same cycle as imem_addr
if_instr  output  DATA_W  registered instruction to decode
if_pc  output  ADDR_W  registered address of if_instr
if_valid  output  1  if_instr/if_pc hold an unconsumed instruction
if_ready  input  1  decode accepts the instruction when if_valid && if_ready
redirect_valid  input  1  one-cycle request to load a new pc
redirect_pc  input  ADDR_W  redirect target
halted  output  1  high while in HALT
issue_count  output  CNT_W  number of instructions issued; saturates at all-ones

Behaviour:
- Reset is synchronous, active-high, and overrides everything in the same edge:
  - pc=0, state=IDLE, if_instr=0, if_pc=0, if_valid=0, halted=0, issue_count=0.
  - Reset asserted mid-stream drops any pending instruction with no handshake.
- States:
  - IDLE: exactly one cycle after reset release. imem_addr=0, nothing loaded. This gives memory its one-edge load. Unconditional transition to RUN; a redirect in IDLE is applied and also goes to RUN.
  - RUN: normal fetch.
  - HALT: pc frozen, no fetch.
- Load condition in RUN: load = !if_valid || if_ready.
  - load=1 and imem_data != HALT_WORD: if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+1 (mod 2^ADDR_W, so 31 wraps to 0). issue_count increments, saturating.
  - load=1 and imem_data == HALT_WORD: if_valid<=0, pc unchanged, state<=HALT, halted<=1 on the next cycle. The halt word is not issued and not counted.
  - load=0 (stall): pc, if_instr, if_pc and if_valid all hold; imem_addr stays stable.
- Throughput: one instruction per cycle while if_ready=1. The first if_valid rises on the second rising edge after reset deasserts (IDLE edge, then first RUN edge).
- Redirect (redirect_valid=1) has priority over load, stall and halt in any non-reset state:
  - pc<=redirect_pc, if_valid<=0 (flushes a held instruction even under stall), state<=RUN, halted<=0.
  - issue_count is not changed.
  - The instruction at redirect_pc is fetched the following cycle.
- A handshake completing in the same cycle as a redirect counts as consumed. The flush discards only what the fetch unit would otherwise have loaded.
- HALT exits only via redirect or reset. In HALT, if_valid=0 and imem_addr=pc of the halt word.
- No combinational path from if_ready or redirect_* to imem_addr; imem_addr depends only on the pc register.

Test Plan:
- Reset, then free-run with if_ready=1 and a memory image of addr0..4 = 0x0,0x1,0x2,0x3,0x2:
  - if_valid rises on the 2nd edge after reset release.
  - Issued pairs (pc,instr) are (0,0x0),(1,0x1),(2,0x2),(3,0x3),(4,0x2) on consecutive cycles.
  - issue_count=5.
- Stall:
  - Hold if_ready=0 for 3 cycles while if_instr=0x2 at pc=2: if_instr, if_pc, if_valid and imem_addr=3 stay constant.
  - Releasing if_ready issues pc=3 next, with no skipped or duplicated instruction.
- Redirect during stall: redirect_valid=1 with redirect_pc=9 while if_valid=1 and if_ready=0 → next cycle if_valid=0, imem_addr=9; the cycle after, if_pc=9 and if_instr=mem[9].
- Halt with HALT_WORD=32'h0000_0003:
  - Fetch from 0 issues pc 0..2, then halted=1, if_valid=0, imem_addr=3, issue_count=3.
  - redirect_pc=5 resumes with if_pc=5 and halted=0.
- Wrap-around: redirect to 30 → issued pcs are 30, 31, 0, 1.
- Reset mid-stream: assert reset while if_valid=1 and pc=7 → after the edge all outputs are 0, and the restart issues from pc=0.
